// File: rtl/svc_sim_console_pkg.sv
// Shared types and helpers for the simulation UART console.
package svc_sim_console_pkg;

    // Per-channel receiver states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // End-of-transmission byte that ends a run by default
    localparam logic [7:0] DEFAULT_DONE_BYTE = 8'h04;

    // Clocks per UART bit, truncated
    function automatic int cpb(input int clock_freq_mhz, input int baud);
        return (clock_freq_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/svc_sim_uart_rx.sv
// One 8N1 receive channel: 2-flop synchroniser (preset high) plus bit FSM.
// byte_stb/byte_nxt expose the byte one cycle ahead of the registered
// rx_valid/rx_data so the console can act on the same edge.
module svc_sim_uart_rx
    import svc_sim_console_pkg::*;
#(
    parameter int CPB = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       byte_stb,
    output logic [7:0] byte_nxt
);

    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

    logic [1:0]       sync;
    logic             line_s;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             half_hit, full_hit;
    logic             sample, stop_bad;

    assign line_s   = sync[1];
    assign half_hit = (cnt == HALF_M1);
    assign full_hit = (cnt == FULL_M1);
    assign byte_nxt = shift;

    // Synchronise the asynchronous serial line; preset to idle-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], line};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!line_s)                 state_nxt = START;
            START:   if (half_hit)                state_nxt = line_s ? IDLE : DATA;
            DATA:    if (full_hit && idx == 3'd7) state_nxt = STOP;
            STOP:    if (full_hit)                state_nxt = line_s ? IDLE : BREAK;
            BREAK:   if (line_s)                  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Sample and strobe decode
    always_comb begin
        sample   = (state == DATA) && full_hit;
        byte_stb = (state == STOP) && full_hit && line_s;
        stop_bad = (state == STOP) && full_hit && !line_s;
    end

    // Bit timer, data shifter and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= byte_stb;
            frame_err <= stop_bad;
            if (byte_stb) rx_data <= shift;
            // timer restarts at every phase boundary (mid-start, each bit centre)
            if (state == IDLE || state == BREAK || (state == START && half_hit) || full_hit)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (state == IDLE) idx <= '0;
            if (sample) begin
                shift <= {line_s, shift[7:1]};
                idx   <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/svc_sim_uart_console.sv
// Multi-channel UART console with end-of-run and inactivity watchdog.
// Optional console echo: define SVC_SIM_CONSOLE_PRINT_EN.
module svc_sim_uart_console
    import svc_sim_console_pkg::*;
#(
    parameter int         NUM_CH          = 1,
    parameter int         CLOCK_FREQ_MHZ  = 25,
    parameter int         BAUD_RATE       = 115_200,
    parameter logic [7:0] DONE_BYTE       = DEFAULT_DONE_BYTE,
    parameter int         WATCHDOG_CYCLES = 500_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         uart_rx,
    output logic [NUM_CH-1:0]         rx_valid,
    output logic [8*NUM_CH-1:0]       rx_data,
    output logic [NUM_CH-1:0]         frame_err,
    output logic                      done,
    output logic [$clog2(NUM_CH):0]   done_ch,
    output logic                      timeout
);

    localparam int CPB   = cpb(CLOCK_FREQ_MHZ, BAUD_RATE);
    localparam int CH_W  = $clog2(NUM_CH) + 1;
    localparam int WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((WATCHDOG_CYCLES > 0) ? WATCHDOG_CYCLES - 1 : 0);

    logic [NUM_CH-1:0]       byte_stb;
    logic [NUM_CH-1:0][7:0]  byte_nxt;
    logic                    hit;
    logic [CH_W-1:0]         hit_ch;
    logic [WD_W-1:0]         wd_cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        svc_sim_uart_rx #(.CPB(CPB)) u_rx (
            .clk       (clk),
            .rst       (rst),
            .line      (uart_rx[c]),
            .rx_valid  (rx_valid[c]),
            .rx_data   (rx_data[8*c +: 8]),
            .frame_err (frame_err[c]),
            .byte_stb  (byte_stb[c]),
            .byte_nxt  (byte_nxt[c])
        );
    end

    // Find the lowest channel finishing a DONE_BYTE this cycle
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (byte_stb[c] && byte_nxt[c] == DONE_BYTE) begin
                hit    = 1'b1;
                hit_ch = CH_W'(c);
            end
        end
    end

    // Run lifecycle: done / timeout are sticky and lock each other out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            done_ch <= '0;
            timeout <= 1'b0;
            wd_cnt  <= '0;
        end else if (!done && !timeout) begin
            if (hit) begin
                done    <= 1'b1;
                done_ch <= hit_ch;
            end
            // a received byte beats an expiry on the same edge
            if (|byte_stb) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (WATCHDOG_CYCLES != 0 && wd_cnt == WD_LAST) timeout <= 1'b1;
            end
        end
    end

`ifdef SVC_SIM_CONSOLE_PRINT_EN
    logic [NUM_CH-1:0] at_bol;
    logic              done_q, timeout_q;

    // Echo decoded bytes and lifecycle events onto the simulator console
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            at_bol    <= '1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= done;
            timeout_q <= timeout;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rx_valid[c] && rx_data[8*c +: 8] != 8'h0D) begin
                    if (NUM_CH > 1 && at_bol[c]) $write("[ch%0d] ", c);
                    $write("%c", rx_data[8*c +: 8]);
                    at_bol[c] <= (rx_data[8*c +: 8] == 8'h0A);
                end
            end
            if (done && !done_q) $write("\n<<DONE ch %0d>>", done_ch);
            if (timeout && !timeout_q) begin
                $write("\n<<TIMEOUT>>");
                $finish;
            end
        end
    end
`else
    // console echo compiled out; decode and lifecycle logic unchanged
`endif

endmodule

// File: tb/tb_svc_sim_uart_console.sv
// Randomised scoreboard bench for svc_sim_uart_console (3-channel and 1-channel builds).
module tb_svc_sim_uart_console;

    localparam int         CPB   = 10;
    localparam int         WD    = 500;
    localparam int         NCH   = 3;
    localparam int         LANES = NCH + 1;   // lane 3 = single-channel instance fed from line[0]
    localparam logic [7:0] EOT   = 8'h04;
    // drive happens just after a negedge; the next posedge is the "falling edge" cycle
    localparam int         LAT   = 2 + CPB / 2 + 9 * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0]   line = '1;
    logic [NCH-1:0]   rx_valid, frame_err;
    logic [8*NCH-1:0] rx_data;
    logic             done, timeout;
    logic [2:0]       done_ch;
    logic             rx_valid1, frame_err1, done1, timeout1;
    logic [7:0]       rx_data1;
    logic [0:0]       done_ch1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    svc_sim_uart_console #(.NUM_CH(NCH), .CLOCK_FREQ_MHZ(1), .BAUD_RATE(100_000),
                           .DONE_BYTE(EOT), .WATCHDOG_CYCLES(WD)) u_dut (
        .clk(clk), .rst(rst), .uart_rx(line), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_err(frame_err), .done(done), .done_ch(done_ch), .timeout(timeout));

    svc_sim_uart_console #(.NUM_CH(1), .CLOCK_FREQ_MHZ(1), .BAUD_RATE(100_000),
                           .DONE_BYTE(EOT), .WATCHDOG_CYCLES(WD)) u_one (
        .clk(clk), .rst(rst), .uart_rx(line[0]), .rx_valid(rx_valid1), .rx_data(rx_data1),
        .frame_err(frame_err1), .done(done1), .done_ch(done_ch1), .timeout(timeout1));

    typedef struct { int cyc; logic [7:0] d; } exp_t;

    exp_t       vq [LANES][$];
    int         fq [LANES][$];
    int         tests = 0;
    int         fails = 0;
    logic       m_done, m_tmo;
    int         m_dch, m_last;
    logic [7:0] m_data [LANES];

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane %0d cycle %0d: got %0h, expected %0h", name, lane, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected events when due and checks every output each cycle
    always @(negedge clk) begin
        logic [LANES-1:0] v, fe;
        logic [7:0]       dl [LANES];
        v  = {rx_valid1, rx_valid};
        fe = {frame_err1, frame_err};
        for (int l = 0; l < NCH; l++) dl[l] = rx_data[8*l +: 8];
        dl[NCH] = rx_data1;
        if (rst) begin
            chk("reset_strobes", -1, {24'd0, v, fe}, 0);
            chk("reset_data", -1, {rx_data1, rx_data}, 0);
            chk("reset_flags", -1, {done, timeout, done_ch, done1, timeout1, done_ch1}, 0);
            for (int l = 0; l < LANES; l++) begin
                vq[l].delete();
                fq[l].delete();
                m_data[l] = 8'h00;
            end
            m_done = 1'b0;
            m_tmo  = 1'b0;
            m_dch  = 0;
            m_last = cyc;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                exp_t e;
                logic fdue;
                if (vq[l].size() > 0 && vq[l][0].cyc == cyc) begin
                    e = vq[l].pop_front();
                    m_data[l] = e.d;
                    chk("rx_valid_strobe", l, v[l], 1);
                    if (l < NCH) begin
                        m_last = cyc;
                        if (e.d == EOT && !m_done && !m_tmo) begin
                            m_done = 1'b1;
                            m_dch  = l;
                        end
                    end
                end else begin
                    chk("rx_valid_quiet", l, v[l], 0);
                end
                chk("rx_data", l, dl[l], m_data[l]);
                fdue = (fq[l].size() > 0 && fq[l][0] == cyc);
                if (fdue) void'(fq[l].pop_front());
                chk("frame_err", l, fe[l], fdue);
            end
            if (!m_done && !m_tmo && (cyc - m_last) >= WD) m_tmo = 1'b1;
            chk("done", -1, done, m_done);
            chk("done_ch", -1, done_ch, m_dch);
            chk("timeout", -1, timeout, m_tmo);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Serialise one 8N1 frame; a bad stop bit is held low for stop_len cycles
    task automatic send(input int ch, input logic [7:0] d, input bit stop_ok, input int stop_len);
        exp_t e;
        tick();
        e.cyc = cyc + LAT;
        e.d   = d;
        if (stop_ok) begin
            vq[ch].push_back(e);
            if (ch == 0) vq[NCH].push_back(e);
        end else begin
            fq[ch].push_back(e.cyc);
            if (ch == 0) fq[NCH].push_back(e.cyc);
        end
        line[ch] = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            line[ch] = d[i];
            repeat (CPB) tick();
        end
        line[ch] = stop_ok;
        repeat (stop_len) tick();
        line[ch] = 1'b1;
    endtask

    task automatic rand_stream(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            bit         ok;
            repeat ($urandom_range(0, 3)) tick();
            d  = 8'($urandom_range(0, 255));
            if (d == EOT) d = 8'h2A;
            ok = ($urandom_range(0, 4) != 0);
            send(ch, d, ok, ok ? CPB : 2 * CPB);
            if (!ok) repeat (5) tick();
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int v_cyc;
        repeat (3) tick();
        rst = 1'b0;

        // single byte, fixed latency
        send(0, 8'h48, 1, CPB);
        repeat (3) tick();

        // start-bit glitch must be discarded
        line[0] = 1'b0;
        repeat (3) tick();
        line[0] = 1'b1;
        repeat (20) tick();

        // framing error, then clean recovery
        send(0, 8'h55, 0, 2 * CPB);
        repeat (5) tick();
        send(0, 8'hA5, 1, CPB);

        // simultaneous starts on all channels
        fork
            send(0, 8'h31, 1, CPB);
            send(1, 8'h32, 1, CPB);
            send(2, 8'h33, 1, CPB);
        join

        // randomised traffic on every channel
        fork
            rand_stream(0, 6);
            rand_stream(1, 6);
            rand_stream(2, 6);
        join

        // end of run on ch1; later traffic decodes but done_ch stays
        send(1, "o", 1, CPB);
        send(1, "k", 1, CPB);
        send(1, EOT, 1, CPB);
        fork
            send(0, 8'h5A, 1, CPB);
            send(2, EOT, 1, CPB);
        join
        repeat (1000) tick();
        chk("done_after_idle", -1, done, 1);
        chk("done_ch_after_idle", -1, done_ch, 1);
        chk("timeout_blocked_by_done", -1, timeout, 0);

        // watchdog expiry exactly WD cycles after the last strobe
        do_reset();
        v_cyc = cyc + 1 + LAT;
        send(2, 8'hC3, 1, CPB);
        while (cyc < v_cyc + WD - 1) tick();
        chk("timeout_one_early", -1, timeout, 0);
        tick();
        chk("timeout_on_time", -1, timeout, 1);
        send(1, EOT, 1, CPB);
        repeat (5) tick();
        chk("done_blocked_by_timeout", -1, done, 0);

        // reset in the middle of a frame
        do_reset();
        tick();
        line[0] = 1'b0;
        repeat (CPB) tick();
        line[0] = 1'b1;
        repeat (CPB) tick();
        line[0] = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        chk("midframe_reset_valid", -1, {rx_valid1, rx_valid}, 0);
        chk("midframe_reset_flags", -1, {done, timeout}, 0);
        line[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (150) tick();

        for (int l = 0; l < LANES; l++) begin
            chk("rx_queue_drained", l, vq[l].size(), 0);
            chk("ferr_queue_drained", l, fq[l].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: stimulus did not complete");
        $fatal(1);
    end

endmodule
